// File: rtl/spi_regbank_pkg.sv
// Shared types and frame-length helpers for the SPI register-bank peripheral.
package spi_regbank_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, OVERRUN} state_t;

  // R/W bit + address field + data field
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Sizes for the standard 7-bit address / 8-bit data configuration
  localparam int FRAME_LEN = frame_len(7, 8);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, with rise/fall pulses
// taken from the synchronised level against a one-cycle delayed copy.
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= INIT;
      sync2_q <= INIT;
      dly_q   <= INIT;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~dly_q;
  assign fall  = ~sync2_q & dly_q;

endmodule

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 register bank: R/W + address + data frames, writes committed on
// ncs release only for exact-length frames, register read-back on CIPO.
module spi_regbank_peripheral
  import spi_regbank_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int FRAME_BITS = frame_len(ADDR_W, DATA_W);
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 2);
  localparam logic [BIT_CNT_W-1:0] CNT_ADDR_LAST = BIT_CNT_W'(ADDR_W);
  localparam logic [BIT_CNT_W-1:0] CNT_ADDR_DONE = BIT_CNT_W'(ADDR_W + 1);
  localparam logic [BIT_CNT_W-1:0] CNT_FULL      = BIT_CNT_W'(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] CNT_SAT       = BIT_CNT_W'(FRAME_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_sync_edge #(.INIT(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.INIT(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));
  spi_sync_edge #(.INIT(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall};

  state_t                  state_q, state_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d, rx_next;
  logic [DATA_W-1:0]       tx_q, tx_d;
  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic [DATA_W-1:0]       regs_d [NUM_REGS];
  logic                    cipo_q, cipo_d, cipo_oe_q, cipo_oe_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;

  logic [ADDR_W-1:0]       rd_addr, frame_addr;
  logic [DATA_W-1:0]       rd_data, frame_data;
  logic                    frame_rw, frame_hit, commit;

  // Lookups: read address comes from the frame including the bit being sampled now
  always_comb begin
    rx_next    = {rx_q[FRAME_BITS-2:0], copi_lvl};
    rd_addr    = rx_next[ADDR_W-1:0];
    frame_rw   = rx_q[FRAME_BITS-1];
    frame_addr = rx_q[DATA_W +: ADDR_W];
    frame_data = rx_q[DATA_W-1:0];
    frame_hit  = 32'(frame_addr) < 32'(NUM_REGS);
    rd_data    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_addr) == i) rd_data = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    regs_d    = regs_q;
    commit    = 1'b0;
    if (ncs_fall) begin
      state_d   = CMD;
      bit_cnt_d = '0;
      rx_d      = '0;
      tx_d      = '0;
    end else if (ncs_rise) begin
      state_d = IDLE;
      commit  = (bit_cnt_q == CNT_FULL) && frame_rw && frame_hit;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && 32'(frame_addr) == i) regs_d[i] = frame_data;
      end
    end else if (sclk_rise && state_q != IDLE) begin
      if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q < CNT_FULL) rx_d = rx_next;
      case (state_q)
        CMD: begin
          if (bit_cnt_q == CNT_ADDR_LAST) begin
            state_d = DATA;
            tx_d    = rx_next[ADDR_W] ? '0 : rd_data;
          end
        end
        DATA: begin
          if (bit_cnt_q == CNT_FULL) state_d = OVERRUN;
        end
        default: ;
      endcase
    // The falling edge that closes the last address bit must not shift, so the
    // MSB is still on CIPO when the controller samples the first data bit.
    end else if (sclk_fall && state_q == DATA && bit_cnt_q > CNT_ADDR_DONE) begin
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end

    wr_strobe_d = commit;
    wr_addr_d   = commit ? frame_addr : wr_addr_q;
    cipo_d      = (state_d == DATA) ? tx_d[DATA_W-1] : 1'b0;
    cipo_oe_d   = ~ncs_lvl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign regs_out[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
  endgenerate

  assign cipo      = cipo_q;
  assign cipo_oe   = cipo_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule
